memcopy_ctrl: RTL and testbench

Block-copy engine that drives the 64-word `memchip_64` bus: it reads N consecutive words from a source address and writes them to consecutive destination addresses. It checks every access against the chip's address map. It also reports a word count, a 16-bit checksum and an error code. It sits directly upstream of the memory chip, owns its `addr`/`in`/`RW` inputs and consumes its `out`.

---
 rtl/memcopy_ctrl_if.sv | 30 +++
 rtl/memcopy_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_memcopy_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/memcopy_ctrl_if.sv
// Request/status and memory-bus signals of the memcopy_ctrl block-copy engine.
// The slave side is the engine; the master side is its requester plus the memory chip.
interface memcopy_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  start, src, dst, len, mem_out,
    output busy, done, err_code, count, checksum, mem_addr, mem_in, mem_rw
  );

  modport master (
    output start, src, dst, len, mem_out,
    input  busy, done, err_code, count, checksum, mem_addr, mem_in, mem_rw
  );
endinterface

// File: rtl/memcopy_ctrl.sv
// Block-copy engine for the 64-word memchip_64 bus: copies len words src->dst in
// ascending order, checking every access against the chip address map.
module memcopy_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  memcopy_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WSETUP = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_SRC   = 2'd2;
  localparam logic [1:0] ERR_DST   = 2'd3;

  function automatic logic is_ram(input logic [ADDR_W-1:0] a);
    return ((a >= 6'h10) && (a <= 6'h17)) || ((a >= 6'h28) && (a <= 6'h2F));
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (a <= 6'h0F) || is_ram(a);
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic              mem_rw_q, mem_rw_d;
  logic              range_bad_s;

  // Start is rejected when either run would step past the top of the 64-word map.
  assign range_bad_s = (({2'b00, bus.src} + {1'b0, bus.len}) > 8'd64) ||
                       (({2'b00, bus.dst} + {1'b0, bus.len}) > 8'd64);

  // Next-state and output computation for the copy sequencer.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    mem_addr_d = mem_addr_q;
    mem_in_d   = mem_in_q;
    mem_rw_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_d      = bus.src;
          dst_d      = bus.dst;
          len_d      = bus.len;
          count_d    = 7'd0;
          checksum_d = 16'd0;
          err_d      = ERR_OK;
          if (range_bad_s) begin
            err_d   = ERR_RANGE;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (bus.len == 7'd0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            busy_d     = 1'b1;
            mem_addr_d = bus.src;
            state_d    = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Both sides are checked here so a failing word never reaches the write phase.
        if (!is_mapped(src_q)) begin
          err_d   = ERR_SRC;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!is_ram(dst_q)) begin
          err_d   = ERR_DST;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          data_d     = bus.mem_out;
          mem_addr_d = dst_q;
          mem_in_d   = bus.mem_out;
          state_d    = WSETUP;
        end
      end
      WSETUP: begin
        mem_rw_d = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        count_d    = count_q + 7'd1;
        checksum_d = checksum_q + data_q;
        src_d      = src_q + 6'd1;
        dst_d      = dst_q + 6'd1;
        if ((count_q + 7'd1) == len_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          mem_addr_d = src_q + 6'd1;
          state_d    = READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops mem_rw without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_q      <= 6'd0;
      dst_q      <= 6'd0;
      len_q      <= 7'd0;
      data_q     <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_OK;
      count_q    <= 7'd0;
      checksum_q <= 16'd0;
      mem_addr_q <= 6'd0;
      mem_in_q   <= 16'd0;
      mem_rw_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      mem_rw_q   <= mem_rw_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_code = err_q;
  assign bus.count    = count_q;
  assign bus.checksum = checksum_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_in   = mem_in_q;
  assign bus.mem_rw   = mem_rw_q;

endmodule

// File: tb/tb_memcopy_ctrl.sv
// Directed bench for memcopy_ctrl with a memchip_64 model and a queue of
// expected copy results built from a behavioural reference copy.
module tb_memcopy_ctrl;

  typedef struct {
    logic [1:0]  err;
    logic [6:0]  cnt;
    logic [15:0] cs;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem    [64];
  logic [15:0] shadow [64];
  int          rw_cnt;
  int          n_cmp;
  int          n_bad;
  exp_t        sb_q[$];

  memcopy_ctrl_if bus ();

  memcopy_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit tb_ram(input logic [5:0] a);
    return ((a >= 6'h10) && (a <= 6'h17)) || ((a >= 6'h28) && (a <= 6'h2F));
  endfunction

  function automatic bit tb_mapped(input logic [5:0] a);
    return (a <= 6'h0F) || tb_ram(a);
  endfunction

  // memchip_64: asynchronous read, write on the rising edge while RW is high.
  assign bus.mem_out = ((bus.mem_addr <= 6'h0F) ||
                        ((bus.mem_addr >= 6'h10) && (bus.mem_addr <= 6'h17)) ||
                        ((bus.mem_addr >= 6'h28) && (bus.mem_addr <= 6'h2F)))
                       ? mem[bus.mem_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (bus.mem_rw === 1'b1) begin
      rw_cnt = rw_cnt + 1;
      if (tb_ram(bus.mem_addr)) mem[bus.mem_addr] = bus.mem_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference copy: word-by-word in ascending order against the shadow memory.
  task automatic model(input logic [5:0] s, input logic [5:0] d, input logic [6:0] n,
                       output exp_t e);
    logic [5:0] a_s;
    logic [5:0] a_d;
    e.err = 2'd0;
    e.cnt = 7'd0;
    e.cs  = 16'd0;
    e.cyc = 1;
    if ((int'(s) + int'(n) > 64) || (int'(d) + int'(n) > 64)) begin
      e.err = 2'd1;
    end else if (n != 7'd0) begin
      e.cyc = 3 * int'(n) + 1;
      for (int k = 0; k < int'(n); k++) begin
        a_s = s + 6'(k);
        a_d = d + 6'(k);
        if (!tb_mapped(a_s)) begin
          e.err = 2'd2;
          e.cyc = 3 * k + 2;
          break;
        end
        if (!tb_ram(a_d)) begin
          e.err = 2'd3;
          e.cyc = 3 * k + 2;
          break;
        end
        shadow[a_d] = shadow[a_s];
        e.cnt = e.cnt + 7'd1;
        e.cs  = e.cs + shadow[a_d];
      end
    end
  endtask

  task automatic run_copy(input string tag, input logic [5:0] s, input logic [5:0] d,
                          input logic [6:0] n, input bit hold);
    exp_t e;
    exp_t got;
    int   cyc;
    int   w0;
    int   bad;
    bit   busy_ok;
    model(s, d, n, e);
    sb_q.push_back(e);
    @(negedge clk);
    bus.src   = s;
    bus.dst   = d;
    bus.len   = n;
    bus.start = 1'b1;
    w0 = rw_cnt;
    @(posedge clk);
    cyc     = 0;
    busy_ok = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (!hold || cyc >= 3) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== (e.cyc > 1)) busy_ok = 1'b0;
      if (cyc >= 400) break;
    end
    bus.start = 1'b0;
    got = sb_q.pop_front();
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(got.cyc));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_err"}, 32'(bus.err_code), 32'(got.err));
    chk({tag, "_count"}, 32'(bus.count), 32'(got.cnt));
    chk({tag, "_checksum"}, 32'(bus.checksum), 32'(got.cs));
    chk({tag, "_writes"}, 32'(rw_cnt - w0), 32'(got.cnt));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_status_hold"}, {7'd0, bus.err_code, bus.count, bus.checksum},
        {7'd0, got.err, got.cnt, got.cs});
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== shadow[i]) bad = bad + 1;
    chk({tag, "_mem"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int wait_cyc;
    n_cmp     = 0;
    n_bad     = 0;
    rw_cnt    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.src   = 6'd0;
    bus.dst   = 6'd0;
    bus.len   = 7'd0;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)          mem[i] = 16'hFFFF - 16'(i);
      else if (tb_ram(6'(i))) mem[i] = 16'h1000 + 16'(i);
      else                 mem[i] = 16'h0000;
      shadow[i] = mem[i];
    end

    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.err_code, bus.count, bus.checksum,
                          bus.mem_addr, bus.mem_in, bus.mem_rw}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {bus.busy, bus.done, bus.mem_rw}, 32'd0);

    run_copy("rom_to_ram", 6'h00, 6'h10, 7'd4, 1'b0);
    chk("rom_to_ram_cs_const", 32'(bus.checksum), 32'h0000FFF6);
    chk("rom_to_ram_mem10", 32'(mem[16]), 32'h0000FFFF);
    chk("rom_to_ram_mem13", 32'(mem[19]), 32'h0000FFFC);

    run_copy("span_rom_ram", 6'h0C, 6'h28, 7'd8, 1'b1);
    chk("span_count_const", 32'(bus.count), 32'd8);
    chk("span_cs_const", 32'(bus.checksum), 32'h0000FFBC);
    chk("span_mem2c", 32'(mem[44]), 32'h0000FFFF);

    run_copy("dst_leaves_ram", 6'h16, 6'h17, 7'd4, 1'b0);
    chk("dst_leaves_ram_const", {bus.err_code, bus.count}, {2'd3, 7'd1});

    run_copy("src_unmapped", 6'h20, 6'h10, 7'd1, 1'b0);
    run_copy("src_leaves_map", 6'h15, 6'h28, 7'd5, 1'b0);
    run_copy("dst_rom", 6'h10, 6'h00, 7'd1, 1'b0);
    run_copy("range", 6'h3F, 6'h10, 7'd2, 1'b0);
    chk("range_const", 32'(bus.err_code), 32'd1);
    run_copy("len_zero", 6'h05, 6'h10, 7'd0, 1'b0);
    run_copy("overlap", 6'h28, 6'h29, 7'd3, 1'b0);
    run_copy("full_ram", 6'h10, 6'h28, 7'd8, 1'b0);

    // Reset in the middle of a write: RW must drop between clock edges.
    @(negedge clk);
    bus.src   = 6'h0A;
    bus.dst   = 6'h2E;
    bus.len   = 7'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc  = 0;
    while (bus.mem_rw !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc = wait_cyc + 1;
    end
    chk("reach_write", 32'(bus.mem_rw), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rw_drop", 32'(bus.mem_rw), 32'd0);
    chk("async_reset_outputs", {bus.busy, bus.done, bus.err_code, bus.count, bus.checksum,
                                bus.mem_addr, bus.mem_in, bus.mem_rw}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) shadow[i] = mem[i];

    run_copy("after_reset", 6'h03, 6'h12, 7'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
